// File: rtl/neuron_accumulate.sv
// neuron_accumulate
// Sums one neuron's signed MAC products over a variable-length vector.
// On the last term it rounds half-up, drops the FRAC_BITS product scaling,
// optionally applies ReLU and saturates to NO_OF_BITS signed. The result is
// held on a valid/ready output until it is taken.
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   in         signed 2*NO_OF_BITS product from the MAC
//   in_valid   in carries a term
//   in_last    final term of the vector (qualified by in_valid)
//   in_ready   a term is accepted this cycle (combinational from out_ready)
//   out        signed NO_OF_BITS result
//   out_valid  out / out_sat / out_count valid
//   out_ready  downstream takes the result
//   out_sat    result was clipped to the signed range
//   out_count  number of terms in the vector, including the last
module neuron_accumulate #(
    parameter int NO_OF_BITS = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_BITS   = 40,
    parameter bit RELU       = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*NO_OF_BITS-1:0] in,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [NO_OF_BITS-1:0]   out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sat,
    output logic [15:0]             out_count
);

    localparam int PW = 2 * NO_OF_BITS;

    // Rounding offset and the signed output range, all at accumulator width.
    localparam logic signed [ACC_BITS-1:0] HALF = ACC_BITS'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_BITS-1:0] MAXV = (ACC_BITS'(1) << (NO_OF_BITS - 1)) - ACC_BITS'(1);
    localparam logic signed [ACC_BITS-1:0] MINV = ~MAXV;

    logic signed [ACC_BITS-1:0] acc;
    logic        [15:0]         cnt;

    logic                       accept;
    logic signed [ACC_BITS-1:0] term;
    logic signed [ACC_BITS-1:0] sum;
    logic signed [ACC_BITS-1:0] rnd;
    logic signed [ACC_BITS-1:0] act;
    logic        [NO_OF_BITS-1:0] res;
    logic                       res_sat;
    logic        [15:0]         cnt_inc;

    // A pending, untaken result blocks the input so it cannot be overwritten.
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    assign term    = {{(ACC_BITS - PW){in[PW-1]}}, in};
    assign sum     = acc + term;
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_comb begin
        rnd     = (sum + HALF) >>> FRAC_BITS;
        act     = (RELU && rnd[ACC_BITS-1]) ? '0 : rnd;
        res     = act[NO_OF_BITS-1:0];
        res_sat = 1'b0;
        if (act > MAXV) begin
            res     = MAXV[NO_OF_BITS-1:0];
            res_sat = 1'b1;
        end else if (act < MINV) begin
            res     = MINV[NO_OF_BITS-1:0];
            res_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            out_count <= '0;
        end else begin
            // Handshake clears valid; a last term accepted in the same cycle
            // reloads it below, so back-to-back results have no bubble.
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                if (in_last) begin
                    out       <= res;
                    out_sat   <= res_sat;
                    out_count <= cnt_inc;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_accumulate.sv
module tb_neuron_accumulate;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in;
    logic        in_valid, in_last, out_ready;

    logic        rdy1, rdy0, v1, v0, s1, s0;
    logic [15:0] out1, out0, cnt1, cnt0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Two instances share the input stream: one with ReLU, one without.
    neuron_accumulate #(.RELU(1'b1)) u1 (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy1), .out(out1), .out_valid(v1), .out_ready(out_ready),
        .out_sat(s1), .out_count(cnt1)
    );
    neuron_accumulate #(.RELU(1'b0)) u0 (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy0), .out(out0), .out_valid(v0), .out_ready(out_ready),
        .out_sat(s0), .out_count(cnt0)
    );

    // Records every result handshake on the ReLU instance while enabled.
    logic        mon_en = 1'b0;
    logic [15:0] hsq[$];
    always @(posedge clk)
        if (mon_en && v1 && out_ready) hsq.push_back(out1);

    typedef struct {
        int              n;
        logic [2:0][31:0] t;
        logic [15:0]     o1;
        logic            s1;
        logic [15:0]     o0;
        logic            s0;
    } vec_t;

    function automatic vec_t mk(int n, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                logic [15:0] o1, logic s1, logic [15:0] o0, logic s0);
        vec_t v;
        v.n = n; v.t = {c, b, a};
        v.o1 = o1; v.s1 = s1; v.o0 = o0; v.s0 = s0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        in = d; in_valid = 1'b1; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = mk(3, 32'h00000100, 32'h00000200, 32'h00000300, 16'h0006, 0, 16'h0006, 0);
        tbl[1]  = mk(1, 32'h00000180, 0, 0,                      16'h0002, 0, 16'h0002, 0);
        tbl[2]  = mk(1, 32'h0000017F, 0, 0,                      16'h0001, 0, 16'h0001, 0);
        tbl[3]  = mk(2, 32'hFFFFF000, 32'h00000100, 0,           16'h0000, 0, 16'hFFF1, 0);
        tbl[4]  = mk(3, 32'h40000000, 32'h40000000, 32'h40000000, 16'h7FFF, 1, 16'h7FFF, 1);
        tbl[5]  = mk(3, 32'hC0000000, 32'hC0000000, 32'hC0000000, 16'h0000, 0, 16'h8000, 1);
        tbl[6]  = mk(1, 32'hFFFFFF80, 0, 0,                      16'h0000, 0, 16'h0000, 0);
        tbl[7]  = mk(1, 32'hFFFFFF7F, 0, 0,                      16'h0000, 0, 16'hFFFF, 0);
        tbl[8]  = mk(1, 32'h007FFF00, 0, 0,                      16'h7FFF, 0, 16'h7FFF, 0);
        tbl[9]  = mk(1, 32'h007FFF80, 0, 0,                      16'h7FFF, 1, 16'h7FFF, 1);
        tbl[10] = mk(1, 32'hFF800000, 0, 0,                      16'h0000, 0, 16'h8000, 0);
        tbl[11] = mk(1, 32'hFF7FFF00, 0, 0,                      16'h0000, 0, 16'h8000, 1);

        reset = 1'b1; in = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("rst out",       out1, 16'h0000);
        chk("rst out_valid", v1,   1'b0);
        chk("rst out_sat",   s1,   1'b0);
        chk("rst out_count", cnt1, 16'h0000);
        chk("rst in_ready",  rdy1, 1'b1);

        // Table vectors, one idle handshake cycle after each result.
        foreach (tbl[i]) begin
            chk($sformatf("v%0d pre valid", i), v1, 1'b0);
            for (int j = 0; j < tbl[i].n; j++)
                beat(tbl[i].t[j], j == tbl[i].n - 1);
            chk($sformatf("v%0d valid1", i), v1,   1'b1);
            chk($sformatf("v%0d valid0", i), v0,   1'b1);
            chk($sformatf("v%0d out1", i),   out1, tbl[i].o1);
            chk($sformatf("v%0d sat1", i),   s1,   tbl[i].s1);
            chk($sformatf("v%0d out0", i),   out0, tbl[i].o0);
            chk($sformatf("v%0d sat0", i),   s0,   tbl[i].s0);
            chk($sformatf("v%0d count", i),  cnt1, 16'(tbl[i].n));
            idle(1);
        end
        chk("post tbl valid", v1, 1'b0);

        // Backpressure, then back-to-back results with no bubble.
        mon_en = 1'b1;
        out_ready = 1'b0;
        beat(32'h100, 1'b1);
        chk("bp A valid", v1,   1'b1);
        chk("bp A out",   out1, 16'h0001);
        chk("bp ready",   rdy1, 1'b0);
        in = 32'h200; in_valid = 1'b1; in_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold ready %0d", k), rdy1, 1'b0);
            chk($sformatf("bp hold out %0d", k),   out1, 16'h0001);
            chk($sformatf("bp hold valid %0d", k), v1,   1'b1);
            chk($sformatf("bp hold cnt %0d", k),   cnt1, 16'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp A taken", v1, 1'b0);
        in_last = 1'b1;
        @(posedge clk); #1;
        chk("bp B valid", v1,   1'b1);
        chk("bp B out",   out1, 16'h0004);
        chk("bp B cnt",   cnt1, 16'd2);
        in = 32'h300;
        @(posedge clk); #1;
        chk("b2b C valid", v1,   1'b1);
        chk("b2b C out",   out1, 16'h0003);
        chk("b2b C cnt",   cnt1, 16'd1);
        in_valid = 1'b0; in_last = 1'b0;
        idle(1);
        chk("b2b drained", v1, 1'b0);
        mon_en = 1'b0;
        chk("hs count", hsq.size(), 3);
        if (hsq.size() == 3) begin
            chk("hs A", hsq[0], 16'h0001);
            chk("hs B", hsq[1], 16'h0004);
            chk("hs C", hsq[2], 16'h0003);
        end

        // Reset mid-vector discards the partial sum.
        beat(32'h7000, 1'b0);
        beat(32'h7000, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("mid rst valid", v1, 1'b0);
        beat(32'h100, 1'b1);
        chk("mid rst out",   out1, 16'h0001);
        chk("mid rst count", cnt1, 16'd1);
        idle(1);

        // Reset drops a pending result.
        out_ready = 1'b0;
        beat(32'h100, 1'b1);
        chk("pend valid", v1, 1'b1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        out_ready = 1'b1;
        chk("pend dropped", v1,   1'b0);
        chk("pend ready",   rdy1, 1'b1);

        // Idle gaps mid-vector leave the accumulation untouched.
        beat(32'h100, 1'b0);
        idle(2);
        chk("gap no valid", v1, 1'b0);
        beat(32'h100, 1'b1);
        chk("gap out",   out1, 16'h0002);
        chk("gap count", cnt1, 16'd2);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_accumulate.md
# neuron_accumulate

Consumes the 2*NO_OF_BITS-bit signed product stream of the DSP MAC stage and sums one neuron's weighted inputs over a variable-length vector. At the end of the vector it rounds, rescales and optionally applies ReLU, then saturates the result back to NO_OF_BITS signed fixed point. The result is presented on a valid/ready output to the next layer's input buffer. The block sits directly downstream of the MAC in the FPGA neural-network datapath.

## Interface
- NO_OF_BITS, 16, width of the fixed-point data word (signed, FRAC_BITS fractional bits)
- FRAC_BITS, 8, fractional bits per operand; products carry 2*FRAC_BITS
- ACC_BITS, 40, accumulator width; must be at least 2*NO_OF_BITS+1
- RELU, 1, 1 = clamp negative results to 0, 0 = pass through
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- in  input  2*NO_OF_BITS  signed product from the MAC
- in_valid  input  1  `in` carries a valid term
- in_last  input  1  qualifies the final term of a vector; ignored unless in_valid
- in_ready  output  1  block accepts a term this cycle
- out  output  NO_OF_BITS  signed result
- out_valid  output  1  `out`, out_sat and out_count are valid
- out_ready  input  1  downstream accepts the result
- out_sat  output  1  result was clipped to the signed range
- out_count  output  16  number of terms in the vector, including the last

## Operation
- Accept rule: a term is accepted when in_valid && in_ready. `in_ready = !(out_valid && !out_ready)`; this is combinational from out_ready.
- Accumulator `acc` is ACC_BITS wide and signed. Each input term is sign-extended to ACC_BITS before use.
- Accepted term, not last:
  - acc <= acc + sext(in)
  - term counter `cnt` <= cnt + 1 (saturates at 0xFFFF)
- Accepted term with in_last. The final sum `s = acc + sext(in)` is post-processed in the same cycle:
  - round: `r = (s + 2^(FRAC_BITS-1)) >>> FRAC_BITS` (arithmetic shift, round half up)
  - ReLU: if RELU and r < 0, then r = 0
  - saturate: if r > 2^(NO_OF_BITS-1)-1, out = max and out_sat = 1; if r < -2^(NO_OF_BITS-1), out = min and out_sat = 1; otherwise out = r[NO_OF_BITS-1:0] and out_sat = 0
  - out_count <= cnt + 1; out_valid <= 1
  - acc <= 0; cnt <= 0, so the next vector starts clean
- A single-term vector (in_last on the first term) is legal; out_count = 1.
- Output hold: once out_valid = 1, out, out_sat and out_count remain stable until out_valid && out_ready.
- Output handshake cycle, no new last term: out_valid <= 0.
- Output handshake cycle with a new last term accepted: out_valid stays 1 and the output registers load the new result. There is no bubble.
- Non-last terms continue to accumulate while a result waits, until in_ready drops.
- Accumulator overflow is not detected; acc wraps at ACC_BITS. Vector length must be sized so that overflow cannot occur.

## Timing
- Reset values:
  - out = 0, out_valid = 0, out_sat = 0, out_count = 0
  - acc = 0, cnt = 0
  - in_ready = 1 after reset, since out_valid = 0
- Latency: result visible with out_valid = 1 one cycle after the clock edge that accepts the in_last term.
- Throughput: one term per cycle, including back-to-back vectors, provided out_ready stays high.
- Backpressure: while out_valid && !out_ready, in_ready = 0 and no term is accepted. No term is lost and no state changes.
- Reset mid-vector: the partial acc and cnt are discarded and a pending result is dropped. The first term after reset begins a new vector.
- in_valid = 0 cycles leave acc, cnt and outputs unchanged, including mid-vector gaps.

## Test plan
- Basic sum: terms 0x00000100, 0x00000200, 0x00000300 (last) -> out = 0x0006, out_sat = 0, out_count = 3, out_valid exactly one cycle after the last beat.
- Rounding: single term 0x00000180 (last) -> out = 0x0002. Single term 0x0000017F (last) -> out = 0x0001.
- ReLU and sign:
  - RELU = 1, terms 0xFFFFF000 then 0x00000100 (last) -> out = 0x0000, out_sat = 0
  - RELU = 0, same terms -> out = 0xFFF1
- Saturation: three terms of 0x40000000 (last on the third) -> out = 0x7FFF, out_sat = 1. With RELU = 0, three terms of 0xC0000000 -> out = 0x8000, out_sat = 1.
- Backpressure and back-to-back:
  - vector A = {0x100 last}, vector B = {0x200, 0x200 last}; hold out_ready = 0 for 4 cycles
  - required: in_ready drops while the A result is pending, out = 0x0001 stable throughout
  - then with out_ready = 1: B's result 0x0004 follows with no extra bubble, and each result is handshaken exactly once
- Reset mid-vector: two non-last terms 0x7000 each, pulse reset, then 0x100 (last) -> out = 0x0001, out_count = 1.
